// File: rtl/pong_gfx_pkg.sv
// Shared definitions for the pong graphics pipeline: screen geometry, colour width,
// pixel-sink state encoding and the framebuffer address helper.
package pong_gfx_pkg;
   localparam int SCREEN_W_DEF = 160;
   localparam int SCREEN_H_DEF = 120;
   localparam int ADDR_W_DEF   = 15;
   localparam int COLOUR_W     = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_CLEAR = 2'd2
   } sink_state_e;

   // Linear address y*screen_w + x; the 160-wide screen uses y*128 + y*32 instead of a multiplier.
   function automatic logic [31:0] fb_addr(input logic [7:0] x, input logic [6:0] y,
                                           input int screen_w);
      logic [31:0] yy;
      yy = {25'd0, y};
      if (screen_w == 160) begin
         return (yy << 5'd7) + (yy << 5'd5) + {24'd0, x};
      end else begin
         return yy * screen_w + {24'd0, x};
      end
   endfunction
endpackage

// File: rtl/vga_pixel_sink_if.sv
// Framebuffer write port: valid/ready handshake carrying a linear address and a colour.
interface vga_pixel_sink_if #(
   parameter int ADDR_W = pong_gfx_pkg::ADDR_W_DEF
) ();
   logic                              mem_valid;
   logic                              mem_ready;
   logic [ADDR_W-1:0]                 mem_addr;
   logic [pong_gfx_pkg::COLOUR_W-1:0] mem_data;

   modport master (output mem_valid, output mem_addr, output mem_data, input mem_ready);
   modport slave  (input mem_valid, input mem_addr, input mem_data, output mem_ready);
endinterface

// File: rtl/vga_pixel_sink_pixel_fifo.sv
// pixel_fifo: synchronous FIFO with first-word fall-through head; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module pixel_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       wdata_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_ok_s, pop_ok_s;

   // Next pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
   always_comb begin
      pop_ok_s  = pop_i && (count_q != {(PTR_W+1){1'b0}});
      push_ok_s = push_i && (!full_o || pop_ok_s);
      rd_ptr_d  = rd_ptr_q + PTR_W'(pop_ok_s);
      wr_ptr_d  = wr_ptr_q + PTR_W'(push_ok_s);
      count_d   = count_q + (PTR_W+1)'(push_ok_s) - (PTR_W+1)'(pop_ok_s);
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rd_ptr_q <= {PTR_W{1'b0}};
         wr_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {(PTR_W+1){1'b0}};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset since occupancy gates every read.
   always_ff @(posedge clock) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == {(PTR_W+1){1'b0}});
   assign count_o = count_q;
endmodule

// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink: turns the plot/x/y/colour stream into framebuffer writes, with FIFO
// buffering, out-of-range drop and ordered full-screen clear. VGA_PIXEL_SINK_STATS_EN adds drop counters.
module vga_pixel_sink
   import pong_gfx_pkg::*;
#(
   parameter int SCREEN_W   = SCREEN_W_DEF,
   parameter int SCREEN_H   = SCREEN_H_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = ADDR_W_DEF
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                plot,
   input  logic [7:0]          vga_x,
   input  logic [6:0]          vga_y,
   input  logic [COLOUR_W-1:0] colour,
   input  logic                clear_req,
   input  logic [COLOUR_W-1:0] clear_colour,
   vga_pixel_sink_if.master    mem,
   output logic                busy,
   output logic                overflow,
   output logic                oob_drop
`ifdef VGA_PIXEL_SINK_STATS_EN
   ,
   output logic [15:0]         drop_count,
   output logic [15:0]         oob_count
`endif
);
   localparam int FIFO_W = ADDR_W + COLOUR_W;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 32'sd1);

   sink_state_e         state_q;
   logic                mem_valid_q, pending_q, pending_d, busy_q, overflow_q, oob_drop_q;
   logic [ADDR_W-1:0]   cnt_q;
   logic [COLOUR_W-1:0] clr_colour_q;

   logic                in_range_s, push_req_s, push_ok_s, pop_s, drop_s;
   logic                last_pop_s, clear_done_s;
   logic [ADDR_W-1:0]   pix_addr_s;
   logic [FIFO_W-1:0]   head_s;
   logic                fifo_full_s, fifo_empty_s;
   logic [CNT_W-1:0]    fifo_count_s, count_next_s;

   pixel_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push_i  (push_ok_s),
      .pop_i   (pop_s),
      .wdata_i ({pix_addr_s, colour}),
      .rdata_o (head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

   // Ingress classification, FIFO traffic and clear bookkeeping for this cycle.
   always_comb begin
      in_range_s   = ({24'd0, vga_x} < 32'(SCREEN_W)) && ({25'd0, vga_y} < 32'(SCREEN_H));
      pix_addr_s   = ADDR_W'(fb_addr(vga_x, vga_y, SCREEN_W));
      push_req_s   = plot && in_range_s;
      pop_s        = (state_q == S_DRAIN) && mem.mem_ready;
      drop_s       = push_req_s && fifo_full_s && !pop_s;
      push_ok_s    = push_req_s && !drop_s;
      count_next_s = fifo_count_s + CNT_W'(push_ok_s) - CNT_W'(pop_s);
      last_pop_s   = pop_s && (count_next_s == {CNT_W{1'b0}});
      clear_done_s = (state_q == S_CLEAR) && mem.mem_ready && (cnt_q == LAST_ADDR);
      if (clear_done_s) begin
         pending_d = 1'b0;
      end else if (clear_req) begin
         pending_d = 1'b1;
      end else begin
         pending_d = pending_q;
      end
   end

   // Write port mux: clear counter while clearing, FIFO head while draining, zero when idle.
   always_comb begin
      mem.mem_valid = mem_valid_q;
      if (state_q == S_CLEAR) begin
         mem.mem_addr = cnt_q;
         mem.mem_data = clr_colour_q;
      end else if (state_q == S_DRAIN) begin
         mem.mem_addr = head_s[FIFO_W-1:COLOUR_W];
         mem.mem_data = head_s[COLOUR_W-1:0];
      end else begin
         mem.mem_addr = {ADDR_W{1'b0}};
         mem.mem_data = {COLOUR_W{1'b0}};
      end
   end

   // Control FSM; pending stays set for the whole clear, so it also covers S_CLEAR in busy.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         mem_valid_q  <= 1'b0;
         cnt_q        <= {ADDR_W{1'b0}};
         clr_colour_q <= {COLOUR_W{1'b0}};
         pending_q    <= 1'b0;
         busy_q       <= 1'b0;
         overflow_q   <= 1'b0;
         oob_drop_q   <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         busy_q     <= (count_next_s != {CNT_W{1'b0}}) || pending_d;
         overflow_q <= overflow_q || drop_s;
         oob_drop_q <= plot && !in_range_s;
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty_s) begin
                  state_q     <= S_DRAIN;
                  mem_valid_q <= 1'b1;
               end else if (pending_q) begin
                  state_q      <= S_CLEAR;
                  mem_valid_q  <= 1'b1;
                  cnt_q        <= {ADDR_W{1'b0}};
                  clr_colour_q <= clear_colour;
               end
            end
            S_DRAIN: begin
               if (last_pop_s) begin
                  state_q     <= S_IDLE;
                  mem_valid_q <= 1'b0;
               end
            end
            S_CLEAR: begin
               if (clear_done_s) begin
                  state_q     <= S_IDLE;
                  mem_valid_q <= 1'b0;
               end else if (mem.mem_ready) begin
                  cnt_q <= cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_q     <= S_IDLE;
               mem_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign overflow = overflow_q;
   assign oob_drop = oob_drop_q;

`ifdef VGA_PIXEL_SINK_STATS_EN
   logic [15:0] drop_count_q, oob_count_q;

   // Saturating counters of FIFO-full and out-of-range losses.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         drop_count_q <= 16'd0;
         oob_count_q  <= 16'd0;
      end else begin
         if (drop_s && (drop_count_q != 16'hFFFF)) begin
            drop_count_q <= drop_count_q + 16'd1;
         end
         if (plot && !in_range_s && (oob_count_q != 16'hFFFF)) begin
            oob_count_q <= oob_count_q + 16'd1;
         end
      end
   end

   assign drop_count = drop_count_q;
   assign oob_count  = oob_count_q;
`endif
endmodule

// File: tb/tb_vga_pixel_sink.sv
// Bench for vga_pixel_sink: directed scenarios plus randomized bursts checked against a
// transaction-level model of expected framebuffer writes.
module tb_vga_pixel_sink;
   logic       clock = 1'b0;
   logic       reset_n;
   logic       plot;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] colour;
   logic       clear_req;
   logic [2:0] clear_colour;
   logic       busy, overflow, oob_drop;
`ifdef VGA_PIXEL_SINK_STATS_EN
   logic [15:0] drop_count, oob_count;
`endif

   vga_pixel_sink_if #(.ADDR_W(15)) mem_bus ();

   vga_pixel_sink dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .plot         (plot),
      .vga_x        (vga_x),
      .vga_y        (vga_y),
      .colour       (colour),
      .clear_req    (clear_req),
      .clear_colour (clear_colour),
      .mem          (mem_bus),
      .busy         (busy),
      .overflow     (overflow),
      .oob_drop     (oob_drop)
`ifdef VGA_PIXEL_SINK_STATS_EN
      ,
      .drop_count   (drop_count),
      .oob_count    (oob_count)
`endif
   );

   always #5 clock = ~clock;

   int          total = 0;
   int          bad   = 0;
   logic [17:0] got_q [$];
   logic [17:0] exp_q [$];
   logic        prev_stall = 1'b0;
   logic [17:0] prev_word  = 18'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic p, input int x, input int y, input logic [2:0] c);
      plot   = p;
      vga_x  = 8'(x);
      vga_y  = 7'(y);
      colour = c;
   endtask

   function automatic logic [17:0] word(input int x, input int y, input logic [2:0] c);
      return {15'(y * 160 + x), c};
   endfunction

   task automatic cmp_q(input string tag);
      int diff = -1;
      int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         if (got_q[i] !== exp_q[i]) begin
            diff = i;
            break;
         end
      end
      chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      chk({tag, "_first_diff_idx"}, 32'(diff), 32'hFFFF_FFFF);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while ((busy || mem_bus.mem_valid) && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_idle_timeout"}, 32'(busy || mem_bus.mem_valid), 32'd0);
   endtask

   task automatic wait_writes(input string tag, input int count, input int budget);
      int n = 0;
      while (got_q.size() < count && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_write_timeout"}, 32'(got_q.size() >= count), 32'd1);
   endtask

   // Write monitor on the inactive edge: records handshakes and checks stall stability.
   always @(negedge clock) begin
      if (!reset_n) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid_held", 32'(mem_bus.mem_valid), 32'd1);
            chk("stall_word_stable", 32'({mem_bus.mem_addr, mem_bus.mem_data}), 32'(prev_word));
         end
         if (mem_bus.mem_valid && mem_bus.mem_ready) begin
            got_q.push_back({mem_bus.mem_addr, mem_bus.mem_data});
         end
         prev_stall <= mem_bus.mem_valid && !mem_bus.mem_ready;
         prev_word  <= {mem_bus.mem_addr, mem_bus.mem_data};
      end
   end

   initial begin
      int n_burst, kind, x, y, snap;
      logic [2:0] c;

      reset_n = 1'b0; plot = 1'b0; vga_x = 8'd0; vga_y = 7'd0; colour = 3'd0;
      clear_req = 1'b0; clear_colour = 3'd0; mem_bus.mem_ready = 1'b0;
      repeat (3) tick();
      chk("rst_valid", 32'(mem_bus.mem_valid), 32'd0);
      chk("rst_addr", 32'(mem_bus.mem_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_oob", 32'(oob_drop), 32'd0);
      reset_n = 1'b1;
      tick();

      // Single pixel latency and address.
      mem_bus.mem_ready = 1'b1; got_q.delete(); exp_q.delete();
      drive(1'b1, 5, 2, 3'b101);
      tick();
      plot = 1'b0;
      chk("t1_valid_after_push", 32'(mem_bus.mem_valid), 32'd0);
      chk("t1_busy_after_push", 32'(busy), 32'd1);
      tick();
      chk("t1_valid_drain", 32'(mem_bus.mem_valid), 32'd1);
      chk("t1_addr", 32'(mem_bus.mem_addr), 32'd325);
      chk("t1_data", 32'(mem_bus.mem_data), 32'd5);
      tick();
      chk("t1_valid_done", 32'(mem_bus.mem_valid), 32'd0);
      chk("t1_busy_done", 32'(busy), 32'd0);
      exp_q.push_back(word(5, 2, 3'b101));
      cmp_q("t1");

      // Overflow under back-pressure.
      mem_bus.mem_ready = 1'b0; got_q.delete(); exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 10 + i, 3, 3'(i));
         tick();
         if (i == 3) chk("t2_ovf_after4", 32'(overflow), 32'd0);
         if (i == 4) chk("t2_ovf_after5", 32'(overflow), 32'd1);
         if (i < 4) exp_q.push_back(word(10 + i, 3, 3'(i)));
      end
      plot = 1'b0;
      repeat (3) tick();
      chk("t2_no_write_stalled", 32'(got_q.size()), 32'd0);
      mem_bus.mem_ready = 1'b1;
      wait_idle("t2", 50);
      cmp_q("t2");
      chk("t2_ovf_sticky", 32'(overflow), 32'd1);
`ifdef VGA_PIXEL_SINK_STATS_EN
      chk("t2_drop_count", 32'(drop_count), 32'd2);
`endif
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("t2_ovf_reset", 32'(overflow), 32'd0);
      tick();

      // Out-of-range drops and the far in-range corner.
      got_q.delete(); exp_q.delete();
      drive(1'b1, 160, 0, 3'd7);
      tick();
      chk("t3_oob_x", 32'(oob_drop), 32'd1);
      drive(1'b1, 0, 120, 3'd7);
      tick();
      chk("t3_oob_y", 32'(oob_drop), 32'd1);
      drive(1'b1, 159, 119, 3'd6);
      tick();
      chk("t3_corner_no_oob", 32'(oob_drop), 32'd0);
      plot = 1'b0;
      wait_idle("t3", 20);
      exp_q.push_back(word(159, 119, 3'd6));
      cmp_q("t3");
`ifdef VGA_PIXEL_SINK_STATS_EN
      chk("t3_oob_count", 32'(oob_count), 32'd2);
`endif

      // Clear ordered behind queued pixels.
      mem_bus.mem_ready = 1'b0; got_q.delete(); exp_q.delete();
      drive(1'b1, 1, 0, 3'd1);
      tick();
      drive(1'b1, 2, 0, 3'd3);
      tick();
      plot = 1'b0; clear_colour = 3'b010; clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (4) tick();
      chk("t4_busy_pending", 32'(busy), 32'd1);
      mem_bus.mem_ready = 1'b1;
      wait_idle("t4", 20100);
      exp_q.push_back(word(1, 0, 3'd1));
      exp_q.push_back(word(2, 0, 3'd3));
      for (int a = 0; a < 19200; a++) exp_q.push_back({15'(a), 3'b010});
      cmp_q("t4");

      // Pixel and a second request arriving during a clear.
      got_q.delete(); exp_q.delete();
      clear_colour = 3'b100; clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      wait_writes("t5", 100, 300);
      drive(1'b1, 1, 1, 3'd7);
      tick();
      plot = 1'b0; clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      wait_idle("t5", 20100);
      for (int a = 0; a < 19200; a++) exp_q.push_back({15'(a), 3'b100});
      exp_q.push_back(word(1, 1, 3'd7));
      cmp_q("t5");

      // Randomized bursts against the write-list model.
      got_q.delete(); exp_q.delete();
      for (int b = 0; b < 40; b++) begin
         n_burst = $urandom_range(1, 4);
         for (int k = 0; k < n_burst; k++) begin
            kind = $urandom_range(0, 5);
            c = 3'($urandom_range(0, 7));
            if (kind == 0) begin
               x = $urandom_range(160, 255); y = $urandom_range(0, 127);
            end else if (kind == 1) begin
               x = $urandom_range(0, 159); y = $urandom_range(120, 127);
            end else begin
               x = $urandom_range(0, 159); y = $urandom_range(0, 119);
            end
            mem_bus.mem_ready = 1'($urandom_range(0, 1));
            drive(1'b1, x, y, c);
            tick();
            chk("rnd_oob_pulse", 32'(oob_drop), 32'(x >= 160 || y >= 120));
            if (x < 160 && y < 120) exp_q.push_back(word(x, y, c));
         end
         plot = 1'b0;
         repeat (3) begin
            mem_bus.mem_ready = 1'($urandom_range(0, 1));
            tick();
            chk("rnd_oob_quiet", 32'(oob_drop), 32'd0);
         end
         mem_bus.mem_ready = 1'b1;
         repeat (8) tick();
      end
      chk("rnd_busy_end", 32'(busy), 32'd0);
      chk("rnd_no_overflow", 32'(overflow), 32'd0);
      cmp_q("rnd");

      // Reset in the middle of a clear.
      got_q.delete();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      wait_writes("t6", 50, 300);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("t6_valid", 32'(mem_bus.mem_valid), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_overflow", 32'(overflow), 32'd0);
      chk("t6_oob", 32'(oob_drop), 32'd0);
      snap = got_q.size();
      repeat (20) tick();
      chk("t6_no_more_writes", 32'(got_q.size()), 32'(snap));
      chk("t6_valid_quiet", 32'(mem_bus.mem_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
